// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam int          QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

  // SQUASH is WAIT with the in-flight response marked for discard.
  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_SQUASH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry {instr, pc} FIFO. Slot 0 is always the head, so the head outputs
// come straight from flops; empty slots hold NOP/0.
module instr_queue
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t ent_q [0:QUEUE_DEPTH-1];
  fetch_entry_t ent_d [0:QUEUE_DEPTH-1];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         valid_q;
  logic         valid_d;
  logic [1:0]   base_s;

  // Next queue contents: flush wins, otherwise pop shifts before push lands.
  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    count_d  = count_q;
    base_s   = count_q;
    if (flush) begin
      ent_d[0] = EMPTY_ENTRY;
      ent_d[1] = EMPTY_ENTRY;
      count_d  = 2'd0;
      base_s   = 2'd0;
    end else begin
      if (pop && (count_q != 2'd0)) begin
        ent_d[0] = ent_q[1];
        ent_d[1] = EMPTY_ENTRY;
        base_s   = count_q - 2'd1;
      end else begin
        base_s   = count_q;
      end
      if (push && (base_s < 2'd2)) begin
        ent_d[base_s[0]] = push_entry;
        count_d          = base_s + 2'd1;
      end else begin
        count_d          = base_s;
      end
    end
    valid_d = (count_d != 2'd0);
  end

  // Queue state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q[0] <= EMPTY_ENTRY;
      ent_q[1] <= EMPTY_ENTRY;
      count_q  <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign head       = ent_q[0];
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch front end: owns the PC, issues one-at-a-time word reads and
// queues returned instructions; taken branches redirect and flush.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCsrc,
  input  logic [31:0] pc_target
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  req_pc_q;
  logic [31:0]  req_pc_d;

  logic         outstanding_s;
  logic         squash_s;
  logic         handshake_s;
  logic         redirect_s;
  logic         pop_s;
  logic         rsp_s;
  logic         issue_s;
  logic [1:0]   q_count_s;
  logic [2:0]   post_count_s;
  fetch_entry_t push_entry_s;
  fetch_entry_t head_s;
  logic         head_valid_s;
  logic         unused_tgt_lsb_s;

  assign outstanding_s    = (state_q != FETCH_IDLE);
  assign squash_s         = (state_q == FETCH_SQUASH);
  assign handshake_s      = head_valid_s && instr_ready;
  assign redirect_s       = handshake_s && PCsrc;
  assign pop_s            = handshake_s && !PCsrc;
  assign rsp_s            = imem_rvalid && !squash_s && !rst;
  assign push_entry_s     = '{instr: imem_rdata, pc: req_pc_q};
  assign unused_tgt_lsb_s = ^pc_target[1:0];

  // Issue only when a slot is still free after this cycle's push/pop.
  always_comb begin
    post_count_s = {1'b0, q_count_s} + {2'b00, rsp_s} - {2'b00, handshake_s};
    if (!rst && !redirect_s && (!outstanding_s || imem_rvalid) && (post_count_s <= 3'd1)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC, request-address and fetch-state next values.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    state_d  = state_q;
    if (redirect_s) begin
      pc_d = word_align(pc_target);
    end else if (issue_s) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
    if (issue_s) begin
      req_pc_d = pc_q;
    end else begin
      req_pc_d = req_pc_q;
    end
    case (state_q)
      FETCH_IDLE: begin
        state_d = issue_s ? FETCH_WAIT : FETCH_IDLE;
      end
      FETCH_WAIT: begin
        if (redirect_s && !imem_rvalid) begin
          state_d = FETCH_SQUASH;
        end else if (imem_rvalid) begin
          state_d = issue_s ? FETCH_WAIT : FETCH_IDLE;
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_SQUASH: begin
        if (imem_rvalid) begin
          state_d = issue_s ? FETCH_WAIT : FETCH_IDLE;
        end else begin
          state_d = FETCH_SQUASH;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req  = issue_s;
  assign imem_addr = issue_s ? pc_q : 32'h0000_0000;

  instr_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_s),
    .head       (head_s),
    .head_valid (head_valid_s),
    .count      (q_count_s)
  );

  assign instr       = head_s.instr;
  assign instr_pc    = head_s.pc;
  assign instr_valid = head_valid_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency memory model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] pc_target = 32'h0;

  int          n_pass = 0;
  int          n_total = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ps;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCsrc       (PCsrc),
    .pc_target   (pc_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdy, input logic ps, input logic [31:0] tgt,
                              input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pc);
    vec_t x;
    x.rst = r; x.rdy = rdy; x.ps = ps; x.tgt = tgt;
    x.req = req; x.addr = addr; x.valid = v; x.pc = pc;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock cycle: drive inputs and memory response at negedge, then log any request.
  task automatic cyc(input logic r, input logic rdy, input logic ps, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; instr_ready = rdy; PCsrc = ps; pc_target = tgt;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if (r) begin
      mem_pend = 1'b0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 1'b0;
      end
    end
    #1;
    if (imem_req && !r) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc);
    check({tag, ".req"},   {31'b0, imem_req},    {31'b0, req});
    check({tag, ".addr"},  imem_addr,            addr);
    check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
    check({tag, ".pc"},    instr_pc,             v ? pc : 32'h0);
    check({tag, ".instr"}, instr,                v ? mem_word(pc) : NOP);
  endtask

  task automatic step(input string tag, input logic r, input logic rdy, input logic ps, input logic [31:0] tgt,
                      input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pc);
    cyc(r, rdy, ps, tgt);
    chk_out(tag, req, addr, v, pc);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].rdy, vecs[i].ps, vecs[i].tgt);
      chk_out($sformatf("%s[%0d]", tag, i), vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc);
    end
    vecs.delete();
  endtask

  task automatic do_reset(input string tag, input int lat);
    mem_lat = lat;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out(tag, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Streaming with 1-cycle memory, then reset mid-stream.
    do_reset("rst_a", 1);
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC,  1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h8));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'hC));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0));
    run_vecs("stream");

    // Ten cycles of backpressure (PCsrc without handshake is ignored), then release.
    do_reset("rst_b", 1);
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4, 1'b0, 32'h0));
    for (int i = 2; i < 10; i++) begin
      vecs.push_back(mk(1'b0, 1'b0, (i == 5), 32'h200, 1'b0, 32'h0, 1'b1, 32'h0));
    end
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,  1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b1, 32'h8));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14, 1'b1, 32'hC));
    run_vecs("stall");

    // 3-cycle memory: redirect on head 0x4 squashes the in-flight 0x8 fetch.
    do_reset("rst_c", 3);
    step("sq0",  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0);
    step("sq1",  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    step("sq2",  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    step("sq3",  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0);
    step("sq4",  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0);
    step("sq5",  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    step("sq6",  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    step("sq7",  1'b0, 1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   1'b1, 32'h4);
    step("sq8",  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    step("sq9",  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
    step("sq10", 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    step("sq11", 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    step("sq12", 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);
    step("sq13", 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100);

    // Redirect in the same cycle as a response: response dropped, no squash left behind.
    do_reset("rst_d", 1);
    step("co0", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0);
    step("co1", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0);
    step("co2", 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  1'b1, 32'h0);
    step("co3", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0);
    step("co4", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h0);
    step("co5", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 32'h40);

    // Reset while a request is outstanding with a queued entry.
    do_reset("rst_e", 3);
    step("ro0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    step("ro1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("ro2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("ro3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0);
    step("ro4", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step("ro5", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    step("ro6", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("ro7", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("ro8", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0);

    // Reset with a full queue.
    do_reset("rst_f", 1);
    step("rf0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    step("rf1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0);
    step("rf2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step("rf3", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step("rf4", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);

    // PC wrap from 0xFFFF_FFFC; target low bits are ignored.
    do_reset("rst_g", 1);
    step("wr0", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0);
    step("wr1", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0);
    step("wr2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 32'h0);
    step("wr3", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step("wr4", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0);
    step("wr5", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC);
    step("wr6", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
